// File: rtl/cpu_defs.sv
// Shared core definitions: pipeline bus widths, bus layouts, load-op encodings
// and exception codes.
package cpu_defs;

   localparam int EM_BUS_W = 230;
   localparam int MW_BUS_W = 211;
   localparam int CANCEL_W = 2;

   // ld_op is one-hot {b, bu, h, hu, w}
   localparam logic [4:0] LD_OP_B  = 5'b10000;
   localparam logic [4:0] LD_OP_BU = 5'b01000;
   localparam logic [4:0] LD_OP_H  = 5'b00100;
   localparam logic [4:0] LD_OP_HU = 5'b00010;
   localparam logic [4:0] LD_OP_W  = 5'b00001;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADE  = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0b;
   localparam logic [5:0] ECODE_BRK  = 6'h0c;
   localparam logic [5:0] ECODE_INE  = 6'h0d;
   localparam logic [5:0] ECODE_TLBR = 6'h3f;

   typedef struct packed {
      logic [5:0]  ecode;
      logic [8:0]  esubcode;
      logic        csr_we;
      logic [13:0] csr_num;
      logic [31:0] csr_wmask;
      logic [31:0] csr_wdata;
      logic [31:0] badv;
      logic [12:0] tlb_op;
   } exc_misc_t;

   // ex_only carries store size/strobe info that EX already used for the request
   typedef struct packed {
      logic [4:0]  ld_op;
      logic        req_sent;
      logic [1:0]  addr;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic [31:0] pc;
      logic [10:0] ex_only;
      logic        exc;
      logic        ertn;
      exc_misc_t   misc;
   } em_bus_t;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] final_wdata;
      logic [31:0] pc;
      logic        exc;
      logic        ertn;
      exc_misc_t   misc;
   } mw_bus_t;

   typedef struct packed {
      logic        load_pending;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] final_wdata;
   } id_bus_t;

   function automatic logic is_load(input logic [4:0] ld_op);
      return |ld_op;
   endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a 32-bit read word and extends it.
module load_align (
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [4:0]  ld_op,
   output logic [31:0] result
);
   import cpu_defs::*;

   logic [15:0] half;
   logic [7:0]  byte_sel;

   // halves need addr[1] only; EX already trapped misaligned halfword loads
   assign half     = addr[1] ? rdata[31:16] : rdata[15:0];
   assign byte_sel = addr[0] ? half[15:8]   : half[7:0];

   always_comb begin
      result = rdata;
      case (ld_op)
         LD_OP_B:  result = {{24{byte_sel[7]}}, byte_sel};
         LD_OP_BU: result = {24'h0, byte_sel};
         LD_OP_H:  result = {{16{half[15]}}, half};
         LD_OP_HU: result = {16'h0, half};
         default:  result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: holds one EX result, waits for its data-SRAM response, aligns load
// data, forwards to ID and hands the result to WB.
module mem_stage #(
   parameter int EM_BUS_W = cpu_defs::EM_BUS_W,
   parameter int MW_BUS_W = cpu_defs::MW_BUS_W,
   parameter int CANCEL_W = cpu_defs::CANCEL_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ex_to_mem_valid,
   input  logic [EM_BUS_W-1:0] ex_to_mem_bus,
   output logic                mem_allowin,
   output logic                mem_to_wb_valid,
   output logic [MW_BUS_W-1:0] mem_to_wb_bus,
   input  logic                wb_allowin,
   input  logic                wb_ex,
   input  logic                ertn_flush,
   input  logic                data_sram_data_ok,
   input  logic [31:0]         data_sram_rdata,
   output logic [38:0]         mem_to_id_bus,
   output logic                mem_to_ex_block
);
   import cpu_defs::*;

   localparam logic [CANCEL_W+1:0] CANCEL_MAX = {2'b00, {CANCEL_W{1'b1}}};

   em_bus_t             ex_in;
   em_bus_t             mem_r;
   logic                mem_valid;
   logic [31:0]         rdata_buf;
   logic                rdata_buf_v;
   logic [CANCEL_W-1:0] cancel_cnt;

   logic        flush;
   logic        mem_exc;
   logic        wait_data;
   logic        data_ok_eff;
   logic        ready_go;
   logic        to_wb_fire;
   logic [31:0] rdata_sel;
   logic [31:0] aligned;
   logic [31:0] final_wdata;

   assign ex_in = ex_to_mem_bus;
   assign flush = wb_ex | ertn_flush;

   assign mem_exc     = mem_r.exc;
   assign wait_data   = mem_valid & mem_r.req_sent & ~mem_exc;
   // responses are owned by cancelled instructions while cancel_cnt is non-zero
   assign data_ok_eff = (data_sram_data_ok & (cancel_cnt == '0)) | rdata_buf_v;
   assign ready_go    = ~wait_data | data_ok_eff;

   assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
   assign mem_to_wb_valid = mem_valid & ready_go & ~flush;
   assign to_wb_fire      = mem_to_wb_valid & wb_allowin;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)            mem_valid <= 1'b0;
      else if (flush)       mem_valid <= 1'b0;
      else if (mem_allowin) mem_valid <= ex_to_mem_valid;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         mem_r <= '0;
      else if (~flush & mem_allowin & ex_to_mem_valid)
         mem_r <= ex_in;
   end

   // park the response while WB stalls so the SRAM is free to answer the next request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_buf_v <= 1'b0;
         rdata_buf   <= 32'h0;
      end else if (flush | to_wb_fire) begin
         rdata_buf_v <= 1'b0;
      end else if (wait_data & ~rdata_buf_v & data_sram_data_ok &
                   (cancel_cnt == '0) & ~wb_allowin) begin
         rdata_buf_v <= 1'b1;
         rdata_buf   <= data_sram_rdata;
      end
   end

   logic                cancel_mem;
   logic                cancel_ex;
   logic                cancel_dec;
   logic [CANCEL_W+1:0] cancel_sum;

   assign cancel_mem = flush & mem_valid & mem_r.req_sent & ~data_ok_eff;
   assign cancel_ex  = flush & ex_to_mem_valid & ex_in.req_sent;
   assign cancel_dec = data_sram_data_ok & (cancel_cnt != '0);
   assign cancel_sum = {2'b00, cancel_cnt}
                     + {{(CANCEL_W+1){1'b0}}, cancel_mem}
                     + {{(CANCEL_W+1){1'b0}}, cancel_ex}
                     - {{(CANCEL_W+1){1'b0}}, cancel_dec};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cancel_cnt <= '0;
      end else begin
         assert (cancel_sum <= CANCEL_MAX);
         cancel_cnt <= (cancel_sum > CANCEL_MAX) ? {CANCEL_W{1'b1}}
                                                 : cancel_sum[CANCEL_W-1:0];
      end
   end

   assign rdata_sel = rdata_buf_v ? rdata_buf : data_sram_rdata;

   load_align u_load_align (
      .rdata  (rdata_sel),
      .addr   (mem_r.addr),
      .ld_op  (mem_r.ld_op),
      .result (aligned)
   );

   assign final_wdata = is_load(mem_r.ld_op) ? aligned : mem_r.rf_wdata;

   mw_bus_t wb_out;
   id_bus_t id_out;

   always_comb begin
      wb_out             = '0;
      wb_out.rf_we       = mem_r.rf_we;
      wb_out.rf_waddr    = mem_r.rf_waddr;
      wb_out.final_wdata = final_wdata;
      wb_out.pc          = mem_r.pc;
      wb_out.exc         = mem_r.exc;
      wb_out.ertn        = mem_r.ertn;
      wb_out.misc        = mem_r.misc;
   end

   always_comb begin
      id_out              = '0;
      id_out.load_pending = mem_valid & is_load(mem_r.ld_op) & ~ready_go;
      id_out.rf_we        = mem_valid & mem_r.rf_we & ~mem_exc;
      id_out.rf_waddr     = mem_r.rf_waddr;
      id_out.final_wdata  = final_wdata;
   end

   assign mem_to_wb_bus   = wb_out;
   assign mem_to_id_bus   = id_out;
   assign mem_to_ex_block = mem_valid & (mem_exc | mem_r.ertn);

   logic unused_ex_only;
   assign unused_ex_only = ^mem_r.ex_only;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: WB results checked against a scoreboard queue,
// handshake/forwarding/cancel behaviour checked at each step.
module tb_mem_stage;
   import cpu_defs::*;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                ex_to_mem_valid = 1'b0;
   logic [EM_BUS_W-1:0] ex_to_mem_bus = '0;
   logic                mem_allowin;
   logic                mem_to_wb_valid;
   logic [MW_BUS_W-1:0] mem_to_wb_bus;
   logic                wb_allowin = 1'b1;
   logic                wb_ex = 1'b0;
   logic                ertn_flush = 1'b0;
   logic                data_sram_data_ok = 1'b0;
   logic [31:0]         data_sram_rdata = 32'h0;
   logic [38:0]         mem_to_id_bus;
   logic                mem_to_ex_block;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ex_to_mem_valid   (ex_to_mem_valid),
      .ex_to_mem_bus     (ex_to_mem_bus),
      .mem_allowin       (mem_allowin),
      .mem_to_wb_valid   (mem_to_wb_valid),
      .mem_to_wb_bus     (mem_to_wb_bus),
      .wb_allowin        (wb_allowin),
      .wb_ex             (wb_ex),
      .ertn_flush        (ertn_flush),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .mem_to_id_bus     (mem_to_id_bus),
      .mem_to_ex_block   (mem_to_ex_block)
   );

   id_bus_t id_o;
   mw_bus_t wb_o;
   assign id_o = mem_to_id_bus;
   assign wb_o = mem_to_wb_bus;

   typedef struct {
      logic [31:0] wdata;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   wb_cnt   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // one clock; a WB handshake seen just before the edge pops the scoreboard
   task automatic cyc();
      exp_t e;
      #1;
      if (!reset && mem_to_wb_valid && wb_allowin) begin
         wb_cnt++;
         n_assert++;
         assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL wb_unexpected observed pc=%08h expected no result", wb_o.pc);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wb_wdata", wb_o.final_wdata, e.wdata);
            chk("wb_pc", wb_o.pc, e.pc);
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic em_bus_t mk(input logic [4:0] op, input logic rs, input logic [1:0] a,
                                  input logic [31:0] wd, input logic [31:0] pc,
                                  input logic exc, input logic ertn);
      em_bus_t e;
      e          = '0;
      e.ld_op    = op;
      e.req_sent = rs;
      e.addr     = a;
      e.rf_we    = 1'b1;
      e.rf_waddr = 5'd7;
      e.rf_wdata = wd;
      e.pc       = pc;
      e.exc      = exc;
      e.ertn     = ertn;
      if (exc) e.misc.ecode = ECODE_SYS;
      return e;
   endfunction

   // reference alignment: index the addressed byte lane directly
   function automatic logic [31:0] model(input logic [4:0] op, input logic [1:0] a,
                                         input logic [31:0] rd);
      int unsigned sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = 8 * int'(a);
      b  = rd[sh +: 8];
      h  = (a == 2'd2) ? rd[31:16] : rd[15:0];
      case (op)
         LD_OP_B:  return {{24{b[7]}}, b};
         LD_OP_BU: return {24'h0, b};
         LD_OP_H:  return {{16{h[15]}}, h};
         LD_OP_HU: return {16'h0, h};
         default:  return rd;
      endcase
   endfunction

   task automatic send(input em_bus_t e);
      #1;
      chkb("send_allowin", mem_allowin, 1'b1);
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = e;
      cyc();
      ex_to_mem_valid = 1'b0;
      ex_to_mem_bus   = '0;
   endtask

   task automatic resp(input logic [31:0] rd, input logic [31:0] exp_wd, input logic [31:0] pc);
      exp_t e;
      e.wdata = exp_wd;
      e.pc    = pc;
      sb.push_back(e);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rd;
      cyc();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
   endtask

   task automatic do_load(input logic [4:0] op, input logic [1:0] a, input logic [31:0] rd,
                          input logic [31:0] pc);
      send(mk(op, 1'b1, a, 32'h0, pc, 1'b0, 1'b0));
      chkb("load_pending_wait", id_o.load_pending, 1'b1);
      resp(rd, model(op, a, rd), pc);
   endtask

   task automatic drop(input string tag);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hBAD0_BAD0;
      #1;
      chkb(tag, mem_to_wb_valid, 1'b0);
      chkb({tag, "_pending"}, id_o.load_pending, 1'b1);
      cyc();
      data_sram_data_ok = 1'b0;
   endtask

   initial begin
      logic [4:0] ops[4];
      ops = '{LD_OP_B, LD_OP_BU, LD_OP_H, LD_OP_HU};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chkb("rst_allowin", mem_allowin, 1'b1);
      chkb("rst_wb_valid", mem_to_wb_valid, 1'b0);
      chkb("rst_wb_bus", |mem_to_wb_bus, 1'b0);
      chkb("rst_id_bus", |mem_to_id_bus, 1'b0);
      chkb("rst_block", mem_to_ex_block, 1'b0);
      reset = 1'b0;
      cyc();

      // 1: ld.b addr 3, response two cycles after entering MEM
      send(mk(LD_OP_B, 1'b1, 2'd3, 32'h0, 32'h1c00_0000, 1'b0, 1'b0));
      chkb("t1_pending_c1", id_o.load_pending, 1'b1);
      chkb("t1_allowin_c1", mem_allowin, 1'b0);
      chkb("t1_wbv_c1", mem_to_wb_valid, 1'b0);
      chkb("t1_fwd_we", id_o.rf_we, 1'b1);
      cyc();
      chkb("t1_pending_c2", id_o.load_pending, 1'b1);
      cyc();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h80FF_FF00;
      #1;
      chkb("t1_pending_done", id_o.load_pending, 1'b0);
      chkb("t1_wbv", mem_to_wb_valid, 1'b1);
      chk("t1_id_wdata", id_o.final_wdata, 32'hFFFF_FF80);
      resp(32'h80FF_FF00, 32'hFFFF_FF80, 32'h1c00_0000);
      chkb("t1_wbv_after", mem_to_wb_valid, 1'b0);
      chk("t1_wb_pulses", 32'(wb_cnt), 32'd1);

      // 2: ld.hu / ld.w plus a sweep of sub-word loads over byte lanes
      do_load(LD_OP_HU, 2'd2, 32'h9ABC_1234, 32'h1c00_0010);
      do_load(LD_OP_W, 2'd0, 32'h9ABC_1234, 32'h1c00_0014);
      chk("t2_hu_const", model(LD_OP_HU, 2'd2, 32'h9ABC_1234), 32'h0000_9ABC);
      for (int a = 0; a < 4; a++)
         for (int k = 0; k < 4; k++)
            if (k < 2 || a[0] == 1'b0)
               do_load(ops[k], 2'(a), 32'h8176_F3A5, 32'h1c00_0100 + 32'(a * 16 + k * 4));

      // 3: response lands while WB stalls for three cycles
      send(mk(LD_OP_W, 1'b1, 2'd0, 32'h0, 32'h1c00_0200, 1'b0, 1'b0));
      wb_allowin = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h1357_9BDF;
      begin
         exp_t e;
         e.wdata = 32'h1357_9BDF;
         e.pc    = 32'h1c00_0200;
         sb.push_back(e);
      end
      #1;
      chkb("t3_wbv_stall", mem_to_wb_valid, 1'b1);
      chkb("t3_allowin_stall", mem_allowin, 1'b0);
      cyc();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         #1;
         chkb("t3_allowin_held", mem_allowin, 1'b0);
         chkb("t3_wbv_held", mem_to_wb_valid, 1'b1);
         chk("t3_buf_data", id_o.final_wdata, 32'h1357_9BDF);
         cyc();
      end
      wb_allowin = 1'b1;
      #1;
      chkb("t3_allowin_release", mem_allowin, 1'b1);
      cyc();
      data_sram_rdata = 32'h0;
      chkb("t3_empty", mem_to_wb_valid, 1'b0);

      // 4: load waiting in MEM, store in EX, exception flush -> two responses dropped
      send(mk(LD_OP_W, 1'b1, 2'd0, 32'h0, 32'h1c00_0300, 1'b0, 1'b0));
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(5'b0, 1'b1, 2'd0, 32'h0, 32'h1c00_0304, 1'b0, 1'b0);
      #1;
      chkb("t4_blocked", mem_allowin, 1'b0);
      wb_ex = 1'b1;
      #1;
      chkb("t4_flush_wbv", mem_to_wb_valid, 1'b0);
      cyc();
      wb_ex = 1'b0;
      ex_to_mem_valid = 1'b0;
      ex_to_mem_bus   = '0;
      chk("t4_cancel_cnt", 32'(dut.cancel_cnt), 32'd2);
      chkb("t4_flushed", mem_allowin, 1'b1);
      send(mk(LD_OP_B, 1'b1, 2'd1, 32'h0, 32'h1c00_0308, 1'b0, 1'b0));
      drop("t4_drop1");
      drop("t4_drop2");
      chk("t4_cancel_zero", 32'(dut.cancel_cnt), 32'd0);
      resp(32'h1234_80FF, model(LD_OP_B, 2'd1, 32'h1234_80FF), 32'h1c00_0308);

      // 5: flush and data_ok together, load in MEM and in EX -> 0 -> 1
      send(mk(LD_OP_W, 1'b1, 2'd0, 32'h0, 32'h1c00_0400, 1'b0, 1'b0));
      ex_to_mem_valid   = 1'b1;
      ex_to_mem_bus     = mk(LD_OP_W, 1'b1, 2'd0, 32'h0, 32'h1c00_0404, 1'b0, 1'b0);
      ertn_flush        = 1'b1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h5555_AAAA;
      #1;
      chkb("t5_flush_wbv", mem_to_wb_valid, 1'b0);
      cyc();
      ertn_flush        = 1'b0;
      data_sram_data_ok = 1'b0;
      ex_to_mem_valid   = 1'b0;
      ex_to_mem_bus     = '0;
      chk("t5_cancel_cnt", 32'(dut.cancel_cnt), 32'd1);
      chkb("t5_valid_cleared", mem_allowin, 1'b1);
      // pending load flushed while a dropped response arrives: +1 -1 nets out
      send(mk(LD_OP_W, 1'b1, 2'd0, 32'h0, 32'h1c00_0408, 1'b0, 1'b0));
      wb_ex = 1'b1;
      data_sram_data_ok = 1'b1;
      cyc();
      wb_ex = 1'b0;
      data_sram_data_ok = 1'b0;
      chk("t5_net_cnt", 32'(dut.cancel_cnt), 32'd1);
      data_sram_data_ok = 1'b1;
      cyc();
      data_sram_data_ok = 1'b0;
      chk("t5_drained", 32'(dut.cancel_cnt), 32'd0);

      // 6: syscall and ertn pass straight through and block EX
      send(mk(5'b0, 1'b0, 2'd0, 32'hCAFE_0001, 32'h1c00_0500, 1'b1, 1'b0));
      chkb("t6_sys_block", mem_to_ex_block, 1'b1);
      chkb("t6_sys_wbv", mem_to_wb_valid, 1'b1);
      chkb("t6_sys_fwd_we", id_o.rf_we, 1'b0);
      begin
         exp_t e;
         e.wdata = 32'hCAFE_0001;
         e.pc    = 32'h1c00_0500;
         sb.push_back(e);
      end
      cyc();
      chkb("t6_block_clear", mem_to_ex_block, 1'b0);
      send(mk(5'b0, 1'b0, 2'd0, 32'h0000_0042, 32'h1c00_0504, 1'b0, 1'b1));
      chkb("t6_ertn_block", mem_to_ex_block, 1'b1);
      begin
         exp_t e;
         e.wdata = 32'h0000_0042;
         e.pc    = 32'h1c00_0504;
         sb.push_back(e);
      end
      cyc();

      // reset in the middle of a wait with a non-zero cancel count
      send(mk(LD_OP_W, 1'b1, 2'd0, 32'h0, 32'h1c00_0600, 1'b0, 1'b0));
      wb_ex = 1'b1;
      cyc();
      wb_ex = 1'b0;
      chk("t6_pre_rst_cnt", 32'(dut.cancel_cnt), 32'd1);
      send(mk(LD_OP_H, 1'b1, 2'd2, 32'h0, 32'h1c00_0604, 1'b0, 1'b0));
      reset = 1'b1;
      #1;
      chkb("rst_mid_allowin", mem_allowin, 1'b1);
      chkb("rst_mid_pending", id_o.load_pending, 1'b0);
      chkb("rst_mid_wbv", mem_to_wb_valid, 1'b0);
      chk("rst_mid_cnt", 32'(dut.cancel_cnt), 32'd0);
      cyc();
      reset = 1'b0;
      cyc();
      do_load(LD_OP_H, 2'd2, 32'hF00D_1234, 32'h1c00_0700);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
